// File: rtl/lsu_pkg.sv
// Shared types and op decoding for the load/store unit.
// Pure declarations and combinational helpers, so no latency of its own.
// Carries no flow control.
package lsu_pkg;

  // Memory Mode codes; the request op uses the same encoding.
  typedef enum logic [2:0] {
    MODE_LB  = 3'b000,
    MODE_LH  = 3'b001,
    MODE_LW  = 3'b010,
    MODE_LBU = 3'b011,
    MODE_LHU = 3'b100,
    MODE_SB  = 3'b101,
    MODE_SH  = 3'b110,
    MODE_SW  = 3'b111
  } mem_mode_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } lsu_state_e;

  // Access size in bytes: 1, 2 or 4.
  function automatic logic [2:0] op_size(input mem_mode_e op);
    case (op)
      MODE_LB, MODE_LBU, MODE_SB: op_size = 3'd1;
      MODE_LH, MODE_LHU, MODE_SH: op_size = 3'd2;
      default:                    op_size = 3'd4;
    endcase
  endfunction

  function automatic logic op_is_store(input mem_mode_e op);
    case (op)
      MODE_SB, MODE_SH, MODE_SW: op_is_store = 1'b1;
      default:                   op_is_store = 1'b0;
    endcase
  endfunction

  // Loads whose result is sign-extended from the top of the accessed size.
  function automatic logic op_is_signed(input mem_mode_e op);
    case (op)
      MODE_LB, MODE_LH, MODE_LW: op_is_signed = 1'b1;
      default:                   op_is_signed = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/lsu_load_extend.sv
// Extends an assembled load word to WIDTH bits according to the load op.
// Latency: combinational, zero cycles.
// Backpressure: none; output follows the inputs.
module lsu_load_extend
  import lsu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  mem_mode_e          op,
  input  logic [WIDTH-1:0]   word,
  output logic [WIDTH-1:0]   result
);

  logic [2:0] size;
  logic       sgn;

  assign size = op_size(op);
  assign sgn  = op_is_signed(op);

  // Keep the accessed low bytes and fill the rest with the sign or zeros.
  always_comb begin
    result = word;
    case (size)
      3'd1:    result = {{(WIDTH-8){sgn & word[7]}}, word[7:0]};
      3'd2:    result = {{(WIDTH-16){sgn & word[15]}}, word[15:0]};
      default: result = word;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Data-memory initiator: one load/store at a time, misaligned split to bytes or faulted.
// Latency: store 2 / load 3 aligned, split store n+1 / load 2n+1, fault 1 cycle.
// Backpressure: req_ready only in IDLE; the response is a one-cycle pulse that cannot stall.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int WIDTH            = 32,
  parameter int MEM_BYTES        = 64,
  parameter int SPLIT_MISALIGNED = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [2:0]        req_op,
  input  logic [WIDTH-1:0]  req_addr,
  input  logic [WIDTH-1:0]  req_wdata,
  output logic              resp_valid,
  output logic [WIDTH-1:0]  resp_rdata,
  output logic              resp_fault,
  output logic [WIDTH-1:0]  mem_addr,
  output logic [WIDTH-1:0]  mem_wdata,
  output logic [2:0]        mem_mode,
  output logic              mem_write,
  output logic              mem_read,
  input  logic [WIDTH-1:0]  mem_rdata
);

  lsu_state_e       state;
  mem_mode_e        op_q;
  logic [WIDTH-1:0] addr_q;
  logic [WIDTH-1:0] wdata_q;
  logic [WIDTH-1:0] asm_q;
  logic [1:0]       idx_q;
  logic [2:0]       nbytes_q;
  logic             split_q;
  logic             fault_q;

  // Last issued strobe fields, so the memory port holds steady between accesses.
  logic [WIDTH-1:0] hold_addr;
  logic [WIDTH-1:0] hold_wdata;
  mem_mode_e        hold_mode;

  // ---- request decode (used only in IDLE) ----
  mem_mode_e      req_mode;
  logic [2:0]     req_size;
  logic           req_misaligned;
  logic [WIDTH:0] req_end;
  logic           req_out_of_range;
  logic           req_split;
  logic           req_fault;

  assign req_mode         = mem_mode_e'(req_op);
  assign req_size         = op_size(req_mode);
  assign req_misaligned   = (req_size == 3'd2 && req_addr[0]) ||
                            (req_size == 3'd4 && req_addr[1:0] != 2'b00);
  // One extra bit so addresses near the top of the space cannot wrap into range.
  assign req_end          = {1'b0, req_addr} + {{(WIDTH-2){1'b0}}, req_size};
  assign req_out_of_range = req_end > (WIDTH+1)'(MEM_BYTES);
  assign req_split        = req_misaligned && (SPLIT_MISALIGNED != 0);
  assign req_fault        = req_out_of_range || (req_misaligned && (SPLIT_MISALIGNED == 0));

  // ---- issue-side decode ----
  logic             is_store;
  logic             last_byte;
  logic             in_issue;
  logic [7:0]       wbyte;
  logic [WIDTH-1:0] issue_addr;
  logic [WIDTH-1:0] issue_wdata;
  mem_mode_e        issue_mode;
  logic [WIDTH-1:0] ext_rdata;

  assign is_store  = op_is_store(op_q);
  assign last_byte = ({1'b0, idx_q} == (nbytes_q - 3'd1));
  assign in_issue  = (state == ST_ISSUE);

  // Pick the store byte for the current split index.
  always_comb begin
    wbyte = wdata_q[7:0];
    case (idx_q)
      2'd0:    wbyte = wdata_q[7:0];
      2'd1:    wbyte = wdata_q[15:8];
      2'd2:    wbyte = wdata_q[23:16];
      default: wbyte = wdata_q[31:24];
    endcase
  end

  assign issue_addr  = split_q ? addr_q + WIDTH'(idx_q) : addr_q;
  assign issue_wdata = split_q ? {{(WIDTH-8){1'b0}}, wbyte} : wdata_q;
  assign issue_mode  = split_q ? (is_store ? MODE_SB : MODE_LBU) : op_q;

  // ---- memory port: strobes only in ISSUE, fields held otherwise ----
  assign mem_write = in_issue && is_store;
  assign mem_read  = in_issue && !is_store;
  assign mem_addr  = in_issue ? issue_addr  : hold_addr;
  assign mem_wdata = in_issue ? issue_wdata : hold_wdata;
  assign mem_mode  = in_issue ? issue_mode  : hold_mode;

  // ---- request / response handshake ----
  assign req_ready  = (state == ST_IDLE);
  assign resp_valid = (state == ST_DONE);
  assign resp_fault = resp_valid && fault_q;
  assign resp_rdata = (resp_valid && !fault_q && !is_store) ? ext_rdata : '0;

  lsu_load_extend #(.WIDTH(WIDTH)) u_extend (
    .op     (op_q),
    .word   (asm_q),
    .result (ext_rdata)
  );

  // Remember the fields of each issued access for the idle cycles that follow.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hold_addr  <= '0;
      hold_wdata <= '0;
      hold_mode  <= MODE_LB;
    end else if (in_issue) begin
      hold_addr  <= issue_addr;
      hold_wdata <= issue_wdata;
      hold_mode  <= issue_mode;
    end
  end

  // Sequencer: accept, strobe memory once per byte or word, collect read data, respond.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= ST_IDLE;
      op_q     <= MODE_LB;
      addr_q   <= '0;
      wdata_q  <= '0;
      asm_q    <= '0;
      idx_q    <= 2'd0;
      nbytes_q <= 3'd0;
      split_q  <= 1'b0;
      fault_q  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            op_q     <= req_mode;
            addr_q   <= req_addr;
            wdata_q  <= req_wdata;
            asm_q    <= '0;
            idx_q    <= 2'd0;
            fault_q  <= req_fault;
            split_q  <= req_split && !req_fault;
            nbytes_q <= req_split ? req_size : 3'd1;
            state    <= req_fault ? ST_DONE : ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (is_store) begin
            if (last_byte) begin
              state <= ST_DONE;
            end else begin
              idx_q <= idx_q + 2'd1;
            end
          end else begin
            state <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (split_q) begin
            case (idx_q)
              2'd0:    asm_q[7:0]   <= mem_rdata[7:0];
              2'd1:    asm_q[15:8]  <= mem_rdata[7:0];
              2'd2:    asm_q[23:16] <= mem_rdata[7:0];
              default: asm_q[31:24] <= mem_rdata[7:0];
            endcase
          end else begin
            asm_q <= mem_rdata;
          end
          if (last_byte) begin
            state <= ST_DONE;
          end else begin
            idx_q <= idx_q + 2'd1;
            state <= ST_ISSUE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench: split-enabled unit driven against a byte memory, plus a fault-mode unit.
// A byte-array reference model predicts every response and its cycle.
// Requests are offered with valid held until ready, including back-to-back.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_valid0 = 1'b0;
  logic [2:0]  req_op = 3'd0;
  logic [31:0] req_addr = 32'd0;
  logic [31:0] req_wdata = 32'd0;
  logic [31:0] mem_rdata = 32'd0;
  logic [31:0] mem_rdata0 = 32'hA5A5A5A5;

  logic        req_ready, resp_valid, resp_fault, mem_write, mem_read;
  logic [31:0] resp_rdata, mem_addr, mem_wdata;
  logic [2:0]  mem_mode;
  logic        req_ready0, resp_valid0, resp_fault0, mem_write0, mem_read0;
  logic [31:0] resp_rdata0, mem_addr0, mem_wdata0;
  logic [2:0]  mem_mode0;

  always #5 clk = ~clk;

  load_store_unit #(.WIDTH(32), .MEM_BYTES(64), .SPLIT_MISALIGNED(1)) dut (
    .clk(clk), .reset(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_fault(resp_fault),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_mode(mem_mode),
    .mem_write(mem_write), .mem_read(mem_read), .mem_rdata(mem_rdata)
  );

  load_store_unit #(.WIDTH(32), .MEM_BYTES(64), .SPLIT_MISALIGNED(0)) dut0 (
    .clk(clk), .reset(rst), .req_valid(req_valid0), .req_ready(req_ready0),
    .req_op(req_op), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid0), .resp_rdata(resp_rdata0), .resp_fault(resp_fault0),
    .mem_addr(mem_addr0), .mem_wdata(mem_wdata0), .mem_mode(mem_mode0),
    .mem_write(mem_write0), .mem_read(mem_read0), .mem_rdata(mem_rdata0)
  );

  typedef struct { int cyc; logic [31:0] rd; logic flt; } exp_t;
  typedef struct { logic [31:0] a; logic [2:0] m; logic [31:0] d; } wr_t;

  exp_t       expq[$];
  wr_t        wlog[$];
  int         total = 0, bad = 0, cyc = 0, nreads = 0, strobe0 = 0;
  logic [7:0] ref_mem [64];
  logic [7:0] dmem [64];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [5:0] bi(input logic [31:0] a, input int i);
    return 6'(a + 32'(i));
  endfunction

  function automatic int size_of(input logic [2:0] op);
    if (op == 3'd0 || op == 3'd3 || op == 3'd5) return 1;
    if (op == 3'd1 || op == 3'd4 || op == 3'd6) return 2;
    return 4;
  endfunction

  // Reference: applies the access to ref_mem and predicts result, fault and latency.
  function automatic void model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] w,
                                input bit split, output logic [31:0] rd, output logic flt,
                                output int lat);
    int sz, n;
    bit mis;
    longint unsigned last;
    sz   = size_of(op);
    mis  = (a % 32'(sz)) != 0;
    last = 64'(a) + 64'(sz);
    flt  = (last > 64) || (mis && !split);
    rd   = 32'd0;
    lat  = 1;
    if (flt) return;
    n = mis ? sz : 1;
    if (op >= 3'd5) begin
      for (int i = 0; i < sz; i++) ref_mem[bi(a, i)] = 8'(w >> (8 * i));
      lat = mis ? n + 1 : 2;
    end else begin
      for (int i = 0; i < sz; i++) rd = rd | (32'(ref_mem[bi(a, i)]) << (8 * i));
      if ((op == 3'd0 || op == 3'd1) && rd[8 * sz - 1]) rd = rd | (32'hFFFFFFFF << (8 * sz));
      lat = mis ? 2 * n + 1 : 3;
    end
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Environment memory: strobes sampled mid-cycle, applied on the next rising edge.
  logic        s_w = 1'b0, s_r = 1'b0;
  logic [31:0] s_a = 32'd0, s_d = 32'd0;
  logic [2:0]  s_m = 3'd0;
  always @(negedge clk) begin
    s_w = mem_write; s_r = mem_read; s_a = mem_addr; s_d = mem_wdata; s_m = mem_mode;
  end
  always @(posedge clk) begin : env_mem
    logic [31:0] v;
    logic [31:0] ia;
    if (!rst && s_w) begin
      for (int i = 0; i < size_of(s_m); i++) begin
        ia = s_a + 32'(i);
        if (ia < 32'd64) dmem[ia[5:0]] = 8'(s_d >> (8 * i));
      end
    end
    if (!rst && s_r) begin
      v = 32'd0;
      for (int i = 0; i < size_of(s_m); i++) begin
        ia = s_a + 32'(i);
        if (ia < 32'd64) v = v | (32'(dmem[ia[5:0]]) << (8 * i));
      end
      if (s_m == 3'd0 && v[7])  v = v | 32'hFFFFFF00;
      if (s_m == 3'd1 && v[15]) v = v | 32'hFFFF0000;
      mem_rdata <= v;
    end
  end

  // Per-cycle compare of the split unit against the model's expected response queue.
  always @(negedge clk) begin : cmp
    logic exp_v;
    wr_t  wr;
    exp_v = (expq.size() > 0) && (expq[0].cyc == cyc);
    chk("resp_valid", 32'(resp_valid), 32'(exp_v));
    if (exp_v) begin
      chk("resp_rdata", resp_rdata, expq[0].rd);
      chk("resp_fault", 32'(resp_fault), 32'(expq[0].flt));
      void'(expq.pop_front());
    end else if (expq.size() > 0 && expq[0].cyc < cyc) begin
      void'(expq.pop_front());
    end
    chk("strobe_exclusive", 32'(mem_write && mem_read), 32'd0);
    if (mem_write) begin
      wr.a = mem_addr; wr.m = mem_mode; wr.d = mem_wdata;
      wlog.push_back(wr);
    end
    if (mem_read) nreads++;
    if (mem_write0 || mem_read0) strobe0++;
  end

  // Offer a request (valid stays high) until accepted; queue the model's expectation.
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] w,
                       output logic [31:0] rd, output logic flt, output int lat, output int acc);
    exp_t e;
    req_valid = 1'b1; req_op = op; req_addr = a; req_wdata = w;
    acc = -1; rd = 32'd0; flt = 1'b0; lat = 0;
    for (int t = 0; t < 64; t++) begin
      if (req_ready) begin
        acc = cyc;
        model(op, a, w, 1'b1, rd, flt, lat);
        e.cyc = acc + lat; e.rd = rd; e.flt = flt;
        expq.push_back(e);
        @(negedge clk); #1;
        return;
      end
      @(negedge clk); #1;
    end
    total++; bad++;
    $display("FAIL accept_timeout: op %0d addr %h never accepted", op, a);
  endtask

  task automatic drain();
    req_valid = 1'b0;
    for (int t = 0; t < 64; t++) begin
      if (expq.size() == 0) return;
      @(negedge clk); #1;
    end
    total++; bad++;
    $display("FAIL resp_timeout: %0d responses outstanding", expq.size());
    expq.delete();
  endtask

  task automatic run(input logic [2:0] op, input logic [31:0] a, input logic [31:0] w,
                     output logic [31:0] rd, output logic flt, output int lat);
    int acc;
    issue(op, a, w, rd, flt, lat, acc);
    drain();
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    logic [31:0] rd;
    logic        flt;
    int          lat, acc1, acc2;
    logic [7:0]  sw13_b [4];
    sw13_b = '{8'h44, 8'h33, 8'h22, 8'h11};
    for (int i = 0; i < 64; i++) begin ref_mem[i] = 8'h00; dmem[i] = 8'h00; end

    #2 rst = 1'b1;
    #2;
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_resp_fault", 32'(resp_fault), 32'd0);
    chk("rst_resp_rdata", resp_rdata, 32'd0);
    chk("rst_mem_write", 32'(mem_write), 32'd0);
    chk("rst_mem_read", 32'(mem_read), 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    chk("rst_mem_mode", 32'(mem_mode), 32'd0);
    @(negedge clk); #1;
    rst = 1'b0;
    @(negedge clk); #1;

    // Aligned word store then loads of every width from the same word.
    wlog.delete();
    run(3'b111, 32'd8, 32'hDEADBEEF, rd, flt, lat);
    chk("sw8_lat", 32'(lat), 32'd2);
    chk("sw8_nwrites", 32'(wlog.size()), 32'd1);
    if (wlog.size() > 0) begin
      chk("sw8_mode", 32'(wlog[0].m), 32'd7);
      chk("sw8_addr", wlog[0].a, 32'd8);
      chk("sw8_data", wlog[0].d, 32'hDEADBEEF);
    end
    run(3'b010, 32'd8, 32'd0, rd, flt, lat);
    chk("lw8_rd", rd, 32'hDEADBEEF);
    chk("lw8_lat", 32'(lat), 32'd3);
    run(3'b000, 32'd9, 32'd0, rd, flt, lat);
    chk("lb9_rd", rd, 32'hFFFFFFBE);
    run(3'b011, 32'd9, 32'd0, rd, flt, lat);
    chk("lbu9_rd", rd, 32'h000000BE);
    run(3'b001, 32'd8, 32'd0, rd, flt, lat);
    chk("lh8_rd", rd, 32'hFFFFBEEF);
    run(3'b100, 32'd8, 32'd0, rd, flt, lat);
    chk("lhu8_rd", rd, 32'h0000BEEF);

    // Misaligned accesses split into byte strobes.
    wlog.delete();
    run(3'b111, 32'd13, 32'h11223344, rd, flt, lat);
    chk("sw13_lat", 32'(lat), 32'd5);
    chk("sw13_nwrites", 32'(wlog.size()), 32'd4);
    for (int i = 0; i < 4 && i < wlog.size(); i++) begin
      chk("sw13_addr", wlog[i].a, 32'd13 + 32'(i));
      chk("sw13_mode", 32'(wlog[i].m), 32'd5);
      chk("sw13_byte", 32'(wlog[i].d[7:0]), 32'(sw13_b[i]));
    end
    run(3'b010, 32'd13, 32'd0, rd, flt, lat);
    chk("lw13_rd", rd, 32'h11223344);
    chk("lw13_lat", 32'(lat), 32'd9);
    run(3'b001, 32'd15, 32'd0, rd, flt, lat);
    chk("lh15_rd", rd, 32'h00001122);
    chk("lh15_lat", 32'(lat), 32'd5);

    // Range boundary: faults never touch memory, the last byte is legal, no wrap.
    wlog.delete(); nreads = 0;
    run(3'b010, 32'd62, 32'd0, rd, flt, lat);
    chk("lw62_fault", 32'(flt), 32'd1);
    chk("lw62_lat", 32'(lat), 32'd1);
    chk("lw62_nwrites", 32'(wlog.size()), 32'd0);
    chk("lw62_nreads", 32'(nreads), 32'd0);
    run(3'b101, 32'd63, 32'h0000005A, rd, flt, lat);
    chk("sb63_fault", 32'(flt), 32'd0);
    run(3'b011, 32'd63, 32'd0, rd, flt, lat);
    chk("lbu63_rd", rd, 32'h0000005A);
    nreads = 0;
    run(3'b010, 32'hFFFFFFFE, 32'd0, rd, flt, lat);
    chk("lw_wrap_fault", 32'(flt), 32'd1);
    chk("lw_wrap_nreads", 32'(nreads), 32'd0);

    // Valid held across two requests: second accepted in the IDLE cycle after DONE.
    issue(3'b010, 32'd8, 32'd0, rd, flt, lat, acc1);
    issue(3'b000, 32'd9, 32'd0, rd, flt, lat, acc2);
    chk("b2b_spacing", 32'(acc2 - acc1), 32'd4);
    drain();

    // Fault-mode unit: misaligned halfword faults next cycle without strobes.
    req_op = 3'b001; req_addr = 32'd15; req_valid0 = 1'b1;
    chk("nosplit_ready", 32'(req_ready0), 32'd1);
    @(negedge clk); #1;
    req_valid0 = 1'b0;
    chk("nosplit_valid", 32'(resp_valid0), 32'd1);
    chk("nosplit_fault", 32'(resp_fault0), 32'd1);
    chk("nosplit_rdata", resp_rdata0, 32'd0);
    @(negedge clk); #1;
    chk("nosplit_pulse", 32'(resp_valid0), 32'd0);
    chk("nosplit_strobes", 32'(strobe0), 32'd0);

    // Reset during the third byte of a split store aborts with no response.
    issue(3'b111, 32'd41, 32'hCAFEF00D, rd, flt, lat, acc1);
    req_valid = 1'b0;
    for (int t = 0; t < 16 && cyc < acc1 + 3; t++) begin @(negedge clk); #1; end
    chk("mid_write", 32'(mem_write), 32'd1);
    chk("mid_addr", mem_addr, 32'd43);
    chk("mid_byte", 32'(mem_wdata[7:0]), 32'h000000FE);
    rst = 1'b1;
    #1;
    expq.delete();
    chk("abort_resp_valid", 32'(resp_valid), 32'd0);
    chk("abort_mem_write", 32'(mem_write), 32'd0);
    chk("abort_mem_read", 32'(mem_read), 32'd0);
    chk("abort_mem_addr", mem_addr, 32'd0);
    chk("abort_mem_wdata", mem_wdata, 32'd0);
    chk("abort_mem_mode", 32'(mem_mode), 32'd0);
    chk("abort_req_ready", 32'(req_ready), 32'd1);
    ref_mem[43] = 8'h00;
    ref_mem[44] = 8'h00;
    @(negedge clk); #1;
    @(negedge clk); #1;
    rst = 1'b0;
    chk("abort_byte43_unwritten", 32'(dmem[43]), 32'd0);
    run(3'b010, 32'd40, 32'd0, rd, flt, lat);
    chk("lw40_after_abort", rd, 32'h00F00D00);

    @(negedge clk); #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Initiator side of the data-memory interface: accepts one load/store request at a time from the core's execute stage and drives the byte-addressed data memory's Address/W_Data/Mode/MemWrite/MemRead/R_Data port.
- Aligned accesses use one native memory access.
- Misaligned halfword/word accesses are split into byte accesses, or faulted, selected by parameter.
- Out-of-range accesses are faulted without touching memory.

Parameters:
- WIDTH, 32, data and address width.
- MEM_BYTES, 64, memory size in bytes; legal byte addresses are 0..MEM_BYTES-1.
- SPLIT_MISALIGNED, 1, 1 = split misaligned accesses into byte accesses; 0 = fault them.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high.
- req_valid  in  1  request present.
- req_ready  out  1  unit idle, request accepted this cycle if req_valid.
- req_op  in  3  mode: 000 LB, 001 LH, 010 LW, 011 LBU, 100 LHU, 101 SB, 110 SH, 111 SW.
- req_addr  in  WIDTH  effective byte address.
- req_wdata  in  WIDTH  store data; the low bytes are used.
- resp_valid  out  1  one-cycle completion pulse.
- resp_rdata  out  WIDTH  load result, extended; 0 for stores and faults.
- resp_fault  out  1  valid with resp_valid; misaligned (SPLIT_MISALIGNED=0) or out of range.
- mem_addr  out  WIDTH  memory Address.
- mem_wdata  out  WIDTH  memory W_Data.
- mem_mode  out  3  memory Mode.
- mem_write  out  1  MemWrite.
- mem_read  out  1  MemRead.
- mem_rdata  in  WIDTH  R_Data; the memory registers it on the clk edge where mem_read=1.

Behaviour:
- Clock and reset: single clock clk; reset is asynchronous, active-high.
- Reset values:
  - state=IDLE; byte index, latched request and assembly register = 0.
  - resp_valid=0, resp_fault=0, resp_rdata=0.
  - mem_write=0, mem_read=0, mem_addr=0, mem_wdata=0, mem_mode=000.
  - req_ready=1 (decoded from IDLE).
- Size: 1 for B/BU, 2 for H/HU, 4 for W.
- Misaligned: size 2 with addr[0]=1, or size 4 with addr[1:0]!=0.
- Out of range: addr+size > MEM_BYTES, computed at WIDTH+1 bits so there is no wrap-around.
- FSM states: IDLE, ISSUE, WAIT, DONE.
- IDLE:
  - req_ready=1.
  - On req_valid, latch op, addr and wdata, and set idx=0.
  - If out of range, or misaligned with SPLIT_MISALIGNED=0, set the fault flag and go to DONE.
  - Otherwise set nbytes: size if misaligned and split, else 1. Go to ISSUE.
- ISSUE (exactly one memory-strobe cycle):
  - Whole access: mem_mode=op, mem_addr=addr, mem_wdata=wdata.
  - Split access: mem_mode=101 (SB) or 011 (LBU), mem_addr=addr+idx, mem_wdata[7:0]=wdata byte idx.
  - Store: mem_write=1. If idx=nbytes-1 go to DONE, else idx+1 and stay in ISSUE.
  - Load: mem_read=1, go to WAIT.
- WAIT:
  - mem_rdata is valid; mem_read=0.
  - Whole access: capture the full word.
  - Split access: place mem_rdata[7:0] at byte lane idx.
  - If idx=nbytes-1 go to DONE, else idx+1 and go back to ISSUE.
- DONE:
  - resp_valid=1 for one cycle, then return to IDLE.
  - Split loads are sign-extended (LH from bit 15, LW none) or zero-extended (LHU).
  - Fault: resp_fault=1, resp_rdata=0.
- Strobe rules:
  - mem_write and mem_read are never both 1.
  - Both are 0 outside ISSUE.
  - mem_addr, mem_wdata and mem_mode hold their last values outside ISSUE.
- Latency from the acceptance cycle to resp_valid:
  - Aligned store: 2 cycles. Aligned load: 3 cycles.
  - Split store: nbytes+1 cycles. Split load: 2*nbytes+1 cycles.
  - Fault: 1 cycle.
- No request is accepted outside IDLE; req_valid held high is ignored until then. Back-to-back spacing is the latency plus 1.
- Reset mid-operation: abort immediately with no resp_valid. Memory bytes already written by a split store stay written unless the memory is also reset.

Decomposition:
- Package lsu_pkg:
  - mem_mode_e enum with the 8 codes above.
  - lsu_state_e enum.
  - Functions op_size(), op_is_store(), op_is_signed().
- Sub-module lsu_load_extend (combinational): takes op and the assembled word, returns the extended result. It is shared by the whole and split paths.

Test Plan:
- SW addr 8 data 0xDEADBEEF, then LW addr 8 -> one mem_write cycle with mode 111; store resp_valid 2 cycles after acceptance; load resp_rdata=0xDEADBEEF 3 cycles after acceptance, resp_fault=0.
- After the above, LB addr 9 -> 0xFFFFFFBE; LBU addr 9 -> 0x000000BE; LH addr 8 -> 0xFFFFBEEF; LHU addr 8 -> 0x0000BEEF.
- SPLIT_MISALIGNED=1:
  - SW addr 13 data 0x11223344 -> four mem_write cycles, addr 13..16, mode 101, bytes 44, 33, 22, 11; resp after 5 cycles.
  - LW addr 13 -> 0x11223344 after 9 cycles.
  - LH addr 15 -> 0x00001122.
- SPLIT_MISALIGNED=0: LH addr 15 -> resp_fault=1 and resp_rdata=0 after 1 cycle; mem_read and mem_write never asserted.
- Range, MEM_BYTES=64: LW addr 62 -> fault, no strobe; SB addr 63 -> succeeds, no fault; LW addr 0xFFFFFFFE -> fault (no wrap).
- Reset asserted during the 3rd byte of a split SW -> all outputs 0 asynchronously, no resp_valid. With req_valid held high across two requests, the second is accepted only in the IDLE cycle after DONE.
